// File: rtl/sfu_ctrl_pkg.sv
// Shared types and defaults for the accumulate/ReLU SFU sequencer.
// No logic or latency; no flow control.
package sfu_ctrl_pkg;

  localparam int ADDR_BW_DEF = 11;
  localparam int CNT_BW_DEF  = 8;
  localparam int KIJ_BW_DEF  = 4;

  // SRAM enables are active-low
  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_FLUSH,
    S_WRITE,
    S_FIN
  } state_e;

endpackage

// File: rtl/sfu_addr_gen.sv
// Psum row/pixel pointers: address visible the cycle after load/step/next_pix.
// No backpressure; the controller strobes one command per cycle.
module sfu_addr_gen
  import sfu_ctrl_pkg::*;
#(
  parameter int ADDR_BW = ADDR_BW_DEF,
  parameter int CNT_BW  = CNT_BW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [ADDR_BW-1:0] base_i,
  input  logic [CNT_BW-1:0]  stride_i,
  input  logic               step_i,
  input  logic               next_pix_i,
  output logic [ADDR_BW-1:0] addr_o,
  output logic [CNT_BW-1:0]  pix_o
);

  logic [ADDR_BW-1:0] row_q, row_d;
  logic [ADDR_BW-1:0] pix_ptr_q, pix_ptr_d;
  logic [CNT_BW-1:0]  pix_q, pix_d;
  logic [ADDR_BW-1:0] stride_ext;

  assign stride_ext = ADDR_BW'(stride_i);

  // row pointer walks base+o+k*N by repeated adds; all sums wrap
  always_comb begin
    row_d     = row_q;
    pix_ptr_d = pix_ptr_q;
    pix_d     = pix_q;
    if (load_i) begin
      row_d     = base_i;
      pix_ptr_d = base_i;
      pix_d     = '0;
    end else if (next_pix_i) begin
      row_d     = pix_ptr_q + ADDR_BW'(1);
      pix_ptr_d = pix_ptr_q + ADDR_BW'(1);
      pix_d     = pix_q + CNT_BW'(1);
    end else if (step_i) begin
      row_d = row_q + stride_ext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= '0;
      pix_ptr_q <= '0;
      pix_q     <= '0;
    end else begin
      row_q     <= row_d;
      pix_ptr_q <= pix_ptr_d;
      pix_q     <= pix_d;
    end
  end

  assign addr_o = row_q;
  assign pix_o  = pix_q;

endmodule

// File: rtl/sfu_seq_ctrl.sv
// Sequences psum reads, SFU accumulate and output writes per pixel; first read 1 cycle after start.
// No backpressure: memories and SFU are fixed-latency; start while busy is ignored.
module sfu_seq_ctrl
  import sfu_ctrl_pkg::*;
#(
  parameter int ADDR_BW = ADDR_BW_DEF,
  parameter int CNT_BW  = CNT_BW_DEF,
  parameter int KIJ_BW  = KIJ_BW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [KIJ_BW-1:0]  n_kij,
  input  logic [CNT_BW-1:0]  n_onij,
  input  logic [ADDR_BW-1:0] pmem_base,
  input  logic [ADDR_BW-1:0] omem_base,
  output logic               busy,
  output logic               done,
  output logic               pmem_cen,
  output logic [ADDR_BW-1:0] pmem_addr,
  output logic               sfu_acc,
  output logic               omem_cen,
  output logic               omem_wen,
  output logic [ADDR_BW-1:0] omem_addr
);

  state_e             state_q, state_d;
  logic [KIJ_BW-1:0]  k_q, k_d, nk_q, nk_d;
  logic [CNT_BW-1:0]  nn_q, nn_d;
  logic [ADDR_BW-1:0] pbase_q, pbase_d, obase_q, obase_d;
  logic               pend_q, pend_d;
  logic               acc_q;
  logic [1:0]         wr_q;
  logic [ADDR_BW-1:0] oa_pipe_q, oa_q;
  logic               ld, step, nxt, go;
  logic [KIJ_BW-1:0]  req_k;
  logic [CNT_BW-1:0]  req_n;
  logic [ADDR_BW-1:0] req_pb, req_ob;
  logic [CNT_BW-1:0]  pix;
  logic [ADDR_BW-1:0] rd_addr;

  // a start seen in FIN is held over so back-to-back jobs are accepted
  assign go     = start | pend_q;
  assign req_k  = pend_q ? nk_q    : n_kij;
  assign req_n  = pend_q ? nn_q    : n_onij;
  assign req_pb = pend_q ? pbase_q : pmem_base;
  assign req_ob = pend_q ? obase_q : omem_base;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    nk_d    = nk_q;
    nn_d    = nn_q;
    pbase_d = pbase_q;
    obase_d = obase_q;
    pend_d  = 1'b0;
    ld      = 1'b0;
    step    = 1'b0;
    nxt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          nk_d    = req_k;
          nn_d    = req_n;
          pbase_d = req_pb;
          obase_d = req_ob;
          k_d     = '0;
          if (req_k == '0 || req_n == '0) begin
            state_d = S_FIN;
          end else begin
            ld      = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        step = 1'b1;
        if (k_q == nk_q - KIJ_BW'(1)) begin
          k_d     = '0;
          state_d = S_GAP;
        end else begin
          k_d = k_q + KIJ_BW'(1);
        end
      end
      S_GAP: begin
        k_d = '0;
        if (pix < nn_q - CNT_BW'(1)) begin
          nxt     = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_WRITE;
      S_WRITE: state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          pend_d  = 1'b1;
          nk_d    = n_kij;
          nn_d    = n_onij;
          pbase_d = pmem_base;
          obase_d = omem_base;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      nk_q    <= '0;
      nn_q    <= '0;
      pbase_q <= '0;
      obase_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      nk_q    <= nk_d;
      nn_q    <= nn_d;
      pbase_q <= pbase_d;
      obase_q <= obase_d;
      pend_q  <= pend_d;
    end
  end

  sfu_addr_gen #(
    .ADDR_BW(ADDR_BW),
    .CNT_BW (CNT_BW)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (ld),
    .base_i    (req_pb),
    .stride_i  (nn_q),
    .step_i    (step),
    .next_pix_i(nxt),
    .addr_o    (rd_addr),
    .pix_o     (pix)
  );

  // psum data lands one cycle after the read; the write trails GAP by two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= 1'b0;
      wr_q      <= 2'b00;
      oa_pipe_q <= '0;
      oa_q      <= '0;
    end else begin
      acc_q <= (state_q == S_READ);
      wr_q  <= {wr_q[0], (state_q == S_GAP)};
      if (state_q == S_GAP) oa_pipe_q <= obase_q + ADDR_BW'(pix);
      if (wr_q[0]) oa_q <= oa_pipe_q;
    end
  end

  assign busy      = (state_q == S_READ) || (state_q == S_GAP) ||
                     (state_q == S_FLUSH) || (state_q == S_WRITE);
  assign done      = (state_q == S_FIN);
  assign pmem_cen  = (state_q == S_READ) ? CEN_ON : CEN_OFF;
  assign pmem_addr = rd_addr;
  assign sfu_acc   = acc_q;
  assign omem_cen  = wr_q[1] ? CEN_ON : CEN_OFF;
  assign omem_wen  = wr_q[1] ? CEN_ON : CEN_OFF;
  assign omem_addr = oa_q;

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Directed bench for sfu_seq_ctrl with a psum SRAM and single-lane SFU model.
// Cycle c of a job is the period after the (c-1)th edge following the start sample.
module tb_sfu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  n_kij;
  logic [7:0]  n_onij;
  logic [10:0] pmem_base, omem_base;
  logic        busy, done, pmem_cen, sfu_acc, omem_cen, omem_wen;
  logic [10:0] pmem_addr, omem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  int   psum_mem [2048];
  int   out_mem  [2048];
  int   rdata_m  = 0;
  int   acc_m    = 0;
  int   res_m    = 0;
  logic acc_d_m  = 1'b0;

  int rd_addr[$], rd_cyc[$], wr_addr[$], wr_cyc[$];
  int done_cyc, acc_err, busy_err, wen_err, errs;
  int b2b_w, b2b_d;

  int e_k1_rd_a[3] = '{0, 1, 2};
  int e_k1_rd_c[3] = '{1, 3, 5};
  int e_k1_wr_a[3] = '{'h20, 'h21, 'h22};
  int e_k1_wr_c[3] = '{4, 6, 8};
  int e_wrap[4]    = '{'h7FE, 'h000, 'h7FF, 'h001};

  always #5 clk = ~clk;

  sfu_seq_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .n_kij    (n_kij),
    .n_onij   (n_onij),
    .pmem_base(pmem_base),
    .omem_base(omem_base),
    .busy     (busy),
    .done     (done),
    .pmem_cen (pmem_cen),
    .pmem_addr(pmem_addr),
    .sfu_acc  (sfu_acc),
    .omem_cen (omem_cen),
    .omem_wen (omem_wen),
    .omem_addr(omem_addr)
  );

  // psum SRAM (1-cycle read) feeding one SFU lane: ReLU latched on the first low acc cycle
  always @(posedge clk) begin
    if (pmem_cen === 1'b0) rdata_m <= psum_mem[pmem_addr];
    if (sfu_acc === 1'b1) begin
      acc_m <= acc_m + rdata_m;
    end else begin
      if (acc_d_m === 1'b1) res_m <= (acc_m > 0) ? acc_m : 0;
      acc_m <= 0;
    end
    acc_d_m <= sfu_acc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_pmem_cen"}, 32'(pmem_cen), 1);
    check({tag, "_omem_cen"}, 32'(omem_cen), 1);
    check({tag, "_omem_wen"}, 32'(omem_wen), 1);
    check({tag, "_sfu_acc"}, 32'(sfu_acc), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pmem_addr"}, 32'(pmem_addr), 0);
    check({tag, "_omem_addr"}, 32'(omem_addr), 0);
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pmem_cen !== 1'b1 || omem_cen !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Issue one job and log every read/write until done (bounded); optional start pokes mid-job.
  task automatic run_job(input int k, input int n, input int pb, input int ob, input bit poke);
    bit exp_acc, exp_busy, live;
    rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_cyc.delete();
    done_cyc = -1; acc_err = 0; busy_err = 0; wen_err = 0;
    live = (k != 0) && (n != 0);
    @(negedge clk);
    n_kij = 4'(k); n_onij = 8'(n); pmem_base = 11'(pb); omem_base = 11'(ob);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp_acc  = live && (c >= 2) && (((c - 2) % (k + 1)) < k) && (((c - 2) / (k + 1)) < n);
      exp_busy = live && (c <= n * (k + 1) + 2);
      if (sfu_acc !== exp_acc) acc_err++;
      if (busy !== exp_busy) busy_err++;
      if (pmem_cen === 1'b0) begin
        rd_addr.push_back(int'(pmem_addr));
        rd_cyc.push_back(c);
      end
      if (omem_cen === 1'b0) begin
        wr_addr.push_back(int'(omem_addr));
        wr_cyc.push_back(c);
        out_mem[omem_addr] = res_m;
        if (omem_wen !== 1'b0) wen_err++;
      end
      if (poke && (c == 2 || c == 5)) begin
        start = 1'b1; n_kij = 4'd7; n_onij = 8'd9; pmem_base = 11'h3A0; omem_base = 11'h555;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; start = 1'b0; n_kij = '0; n_onij = '0; pmem_base = '0; omem_base = '0;
    for (int i = 0; i < 2048; i++) begin psum_mem[i] = 5; out_mem[i] = -99; end
    #1 reset_n = 1'b0;
    #2 check_rst_outs("por");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // K=9, N=16, all psums +5
    run_job(9, 16, 0, 'h100, 1'b0);
    check("k9_nrd", rd_addr.size(), 144);
    errs = 0;
    for (int i = 0; i < rd_addr.size(); i++)
      if (rd_addr[i] != (i % 9) * 16 + i / 9 || rd_cyc[i] != 1 + (i / 9) * 10 + i % 9) errs++;
    check("k9_rd_seq", errs, 0);
    check("k9_nwr", wr_addr.size(), 16);
    errs = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != 'h100 + i || wr_cyc[i] != 12 + 10 * i) errs++;
    check("k9_wr_seq", errs, 0);
    check("k9_done", done_cyc, 163);
    check("k9_acc", acc_err, 0);
    check("k9_busy", busy_err, 0);
    check("k9_wen", wen_err, 0);
    check("k9_pix0_pos", out_mem['h100], 45);
    check("k9_pix15_pos", out_mem['h10F], 45);

    // same job, all psums -5: ReLU clamps to 0
    for (int i = 0; i < 2048; i++) psum_mem[i] = -5;
    out_mem['h100] = -99;
    run_job(9, 16, 0, 'h100, 1'b0);
    check("k9_pix0_neg", out_mem['h100], 0);

    // pmem address wrap-around
    run_job(2, 2, 'h7FE, 0, 1'b0);
    check("wrap_nrd", rd_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_rd%0d", i), (i < rd_addr.size()) ? rd_addr[i] : -1, e_wrap[i]);
    check("wrap_done", done_cyc, 9);

    // degenerate configs
    run_job(0, 5, 0, 0, 1'b0);
    check("k0_done", done_cyc, 1);
    check("k0_nacc", rd_addr.size() + wr_addr.size(), 0);
    check("k0_busy", busy_err, 0);
    idle_check("k0_idle", 4);
    run_job(3, 0, 0, 0, 1'b0);
    check("n0_done", done_cyc, 1);
    check("n0_nacc", rd_addr.size() + wr_addr.size(), 0);
    idle_check("n0_idle", 4);

    // reset during the first READ of pixel 2 (K=2, N=4)
    @(negedge clk);
    n_kij = 4'd2; n_onij = 8'd4; pmem_base = 11'h10; omem_base = 11'h30; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_rd_cen", 32'(pmem_cen), 0);
    check("mid_rd_addr", 32'(pmem_addr), 'h12);
    #2 reset_n = 1'b0;
    #1 check_rst_outs("mid_rst");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    idle_check("post_rst_quiet", 12);

    // K=1, N=3 with ignored starts while busy
    run_job(1, 3, 0, 'h20, 1'b1);
    check("k1_nrd", rd_addr.size(), 3);
    check("k1_nwr", wr_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("k1_rd_a%0d", i), (i < rd_addr.size()) ? rd_addr[i] : -1, e_k1_rd_a[i]);
      check($sformatf("k1_rd_c%0d", i), (i < rd_cyc.size()) ? rd_cyc[i] : -1, e_k1_rd_c[i]);
      check($sformatf("k1_wr_a%0d", i), (i < wr_addr.size()) ? wr_addr[i] : -1, e_k1_wr_a[i]);
      check($sformatf("k1_wr_c%0d", i), (i < wr_cyc.size()) ? wr_cyc[i] : -1, e_k1_wr_c[i]);
    end
    check("k1_done", done_cyc, 9);
    check("k1_acc", acc_err, 0);
    check("k1_busy", busy_err, 0);

    // start in the done cycle: next job's first read two cycles later
    start = 1'b1; n_kij = 4'd1; n_onij = 8'd1; pmem_base = 11'h40; omem_base = 11'h60;
    @(negedge clk);
    start = 1'b0;
    check("b2b_gap_cen", 32'(pmem_cen), 1);
    @(negedge clk);
    check("b2b_rd_cen", 32'(pmem_cen), 0);
    check("b2b_rd_addr", 32'(pmem_addr), 'h40);
    b2b_w = -1; b2b_d = -1;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (omem_cen === 1'b0) b2b_w = int'(omem_addr);
      if (done === 1'b1) begin
        b2b_d = i;
        break;
      end
    end
    check("b2b_wr_addr", b2b_w, 'h60);
    check("b2b_done", b2b_d, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
